// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush/stall control, per-lane operand forwarding
// and saturating bubble/stall performance counters.
module pipe_stage_reg #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 32,
   parameter int NOPS   = 2,
   parameter int WR_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   stall,
   input  logic                   cnt_clr,
   input  logic                   valid_i,
   input  logic [CTRL_W-1:0]      ctrl_i,
   input  logic [DATA_W-1:0]      pc_i,
   input  logic [DATA_W-1:0]      imm_i,
   input  logic [NOPS*DATA_W-1:0] opnd_i,
   input  logic [NOPS*DATA_W-1:0] fwd_data_i,
   input  logic [NOPS-1:0]        fwd_sel_i,
   input  logic [WR_W-1:0]        wr_i,
   output logic                   valid_o,
   output logic [CTRL_W-1:0]      ctrl_o,
   output logic [DATA_W-1:0]      pc_o,
   output logic [DATA_W-1:0]      imm_o,
   output logic [NOPS*DATA_W-1:0] opnd_o,
   output logic [WR_W-1:0]        wr_o,
   output logic [CNT_W-1:0]       bubble_cnt_o,
   output logic [CNT_W-1:0]       stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              valid_reg;
   logic [CTRL_W-1:0] ctrl_reg;
   logic [DATA_W-1:0] pc_reg;
   logic [DATA_W-1:0] imm_reg;
   logic [WR_W-1:0]   wr_reg;
   logic [DATA_W-1:0] opnd_reg [NOPS];
   logic [CNT_W-1:0]  bubble_cnt_reg, bubble_cnt_next;
   logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
   logic              load_en;

   // Payload fields load on flush too; only valid/ctrl/pc are forced to a bubble.
   assign load_en = flush | ~stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         ctrl_reg  <= '0;
         pc_reg    <= '0;
      end else if (flush) begin
         valid_reg <= 1'b0;
         ctrl_reg  <= '0;
         pc_reg    <= '0;
      end else if (!stall) begin
         valid_reg <= valid_i;
         ctrl_reg  <= ctrl_i;
         pc_reg    <= pc_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm_reg <= '0;
         wr_reg  <= '0;
      end else if (load_en) begin
         imm_reg <= imm_i;
         wr_reg  <= wr_i;
      end
   end

   generate
      for (genvar gi = 0; gi < NOPS; gi++) begin : g_lane
         logic [DATA_W-1:0] lane_next;

         assign lane_next = fwd_sel_i[gi] ? fwd_data_i[gi*DATA_W +: DATA_W]
                                          : opnd_i[gi*DATA_W +: DATA_W];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               opnd_reg[gi] <= '0;
            end else if (load_en) begin
               opnd_reg[gi] <= lane_next;
            end
         end

         assign opnd_o[gi*DATA_W +: DATA_W] = opnd_reg[gi];
      end
   endgenerate

   // Clear wins over increment; both counters stick at all-ones.
   always_comb begin
      bubble_cnt_next = bubble_cnt_reg;
      stall_cnt_next  = stall_cnt_reg;
      if (cnt_clr) begin
         bubble_cnt_next = '0;
         stall_cnt_next  = '0;
      end else begin
         if (flush && bubble_cnt_reg != CNT_MAX)
            bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
         if (stall && !flush && stall_cnt_reg != CNT_MAX)
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_reg <= '0;
         stall_cnt_reg  <= '0;
      end else begin
         bubble_cnt_reg <= bubble_cnt_next;
         stall_cnt_reg  <= stall_cnt_next;
      end
   end

   assign valid_o      = valid_reg;
   assign ctrl_o       = ctrl_reg;
   assign pc_o         = pc_reg;
   assign imm_o        = imm_reg;
   assign wr_o         = wr_reg;
   assign bubble_cnt_o = bubble_cnt_reg;
   assign stall_cnt_o  = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed stimulus pushes hand-computed expectations,
// a monitor pops and compares after each clock edge or asynchronous-reset probe.
module tb_pipe_stage_reg;

   localparam int CTRL_W = 16;
   localparam int DATA_W = 32;
   localparam int NOPS   = 2;
   localparam int WR_W   = 5;
   localparam int CNT_W  = 4;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   flush, stall, cnt_clr, valid_i;
   logic [CTRL_W-1:0]      ctrl_i;
   logic [DATA_W-1:0]      pc_i, imm_i;
   logic [NOPS*DATA_W-1:0] opnd_i, fwd_data_i;
   logic [NOPS-1:0]        fwd_sel_i;
   logic [WR_W-1:0]        wr_i;
   logic                   valid_o;
   logic [CTRL_W-1:0]      ctrl_o;
   logic [DATA_W-1:0]      pc_o, imm_o;
   logic [NOPS*DATA_W-1:0] opnd_o;
   logic [WR_W-1:0]        wr_o;
   logic [CNT_W-1:0]       bubble_cnt_o, stall_cnt_o;

   pipe_stage_reg #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NOPS(NOPS), .WR_W(WR_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .cnt_clr(cnt_clr),
      .valid_i(valid_i), .ctrl_i(ctrl_i), .pc_i(pc_i), .imm_i(imm_i), .opnd_i(opnd_i),
      .fwd_data_i(fwd_data_i), .fwd_sel_i(fwd_sel_i), .wr_i(wr_i),
      .valid_o(valid_o), .ctrl_o(ctrl_o), .pc_o(pc_o), .imm_o(imm_o), .opnd_o(opnd_o),
      .wr_o(wr_o), .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        v;
      logic [15:0] ctrl;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [63:0] opnd;
      logic [4:0]  wr;
      logic [3:0]  bc;
      logic [3:0]  sc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   stim_done = 1'b0;
   event async_chk;

   task automatic cmp(input string name, input string field, input logic [63:0] act,
                      input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, want);
      end
   endtask

   // Monitor: compares after every edge, or right after an async-reset probe.
   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk or async_chk);
         #1;
         if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            cmp(x.name, "valid", 64'(valid_o), 64'(x.v));
            cmp(x.name, "ctrl", 64'(ctrl_o), 64'(x.ctrl));
            cmp(x.name, "pc", 64'(pc_o), 64'(x.pc));
            cmp(x.name, "imm", 64'(imm_o), 64'(x.imm));
            cmp(x.name, "opnd", 64'(opnd_o), x.opnd);
            cmp(x.name, "wr", 64'(wr_o), 64'(x.wr));
            cmp(x.name, "bubble_cnt", 64'(bubble_cnt_o), 64'(x.bc));
            cmp(x.name, "stall_cnt", 64'(stall_cnt_o), 64'(x.sc));
            $display("[%0t] %s: valid=%0b pc=0x%0h opnd=0x%0h bc=%0d sc=%0d",
                     $time, x.name, valid_o, pc_o, opnd_o, bubble_cnt_o, stall_cnt_o);
         end
      end
   end

   task automatic push(input string n);
      e.name = n;
      exp_q.push_back(e);
   endtask

   task automatic set_in(input logic v, input logic [15:0] c, input logic [31:0] p,
                         input logic [31:0] im, input logic [31:0] o1, input logic [31:0] o0,
                         input logic [31:0] f1, input logic [31:0] f0, input logic [1:0] sel,
                         input logic [4:0] w);
      valid_i    = v;
      ctrl_i     = c;
      pc_i       = p;
      imm_i      = im;
      opnd_i     = {o1, o0};
      fwd_data_i = {f1, f0};
      fwd_sel_i  = sel;
      wr_i       = w;
   endtask

   task automatic set_exp(input logic v, input logic [15:0] c, input logic [31:0] p,
                          input logic [31:0] im, input logic [31:0] o1, input logic [31:0] o0,
                          input logic [4:0] w);
      e.v    = v;
      e.ctrl = c;
      e.pc   = p;
      e.imm  = im;
      e.opnd = {o1, o0};
      e.wr   = w;
   endtask

   initial begin : stimulus
      rst_n = 1'b0;
      flush = 1'b0; stall = 1'b0; cnt_clr = 1'b0;
      set_in(1'b1, 16'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             2'($urandom), 5'($urandom));
      set_exp(1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
      e.bc = 4'd0; e.sc = 4'd0;

      // 1. reset held with random inputs, then release and load
      @(negedge clk);
      flush = 1'b1; stall = 1'b1;
      push("reset_hold");
      -> async_chk;
      @(negedge clk);
      rst_n = 1'b1; flush = 1'b0; stall = 1'b0;
      set_in(1'b1, 16'h1234, 32'h100, 32'h55, 32'h22, 32'h11, 32'hBB, 32'hAA, 2'b00, 5'd3);
      set_exp(1'b1, 16'h1234, 32'h100, 32'h55, 32'h22, 32'h11, 5'd3);
      push("load_after_reset");

      // 2. forwarding lanes
      @(negedge clk);
      fwd_sel_i = 2'b01;
      set_exp(1'b1, 16'h1234, 32'h100, 32'h55, 32'h22, 32'hAA, 5'd3);
      push("fwd_sel_01");
      @(negedge clk);
      fwd_sel_i = 2'b10;
      set_exp(1'b1, 16'h1234, 32'h100, 32'h55, 32'hBB, 32'h11, 5'd3);
      push("fwd_sel_10");
      @(negedge clk);
      fwd_sel_i = 2'b11;
      set_exp(1'b1, 16'h1234, 32'h100, 32'h55, 32'hBB, 32'hAA, 5'd3);
      push("fwd_sel_11");

      // 3. load then stall three cycles with changing inputs
      @(negedge clk);
      set_in(1'b1, 16'h0A0A, 32'h200, 32'h66, 32'h33, 32'h44, 32'hEE, 32'hFF, 2'b00, 5'd7);
      set_exp(1'b1, 16'h0A0A, 32'h200, 32'h66, 32'h33, 32'h44, 5'd7);
      push("load_pc200");
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         stall = 1'b1;
         set_in(1'b0, 16'h5000 + 16'(i), 32'h300 + 32'(i), 32'h70 + 32'(i), 32'h90 + 32'(i),
                32'hA0 + 32'(i), 32'hC0 + 32'(i), 32'hD0 + 32'(i), 2'b11, 5'(i));
         e.sc = 4'(i);
         push($sformatf("stall_%0d", i));
      end

      // 4. flush and stall together
      @(negedge clk);
      flush = 1'b1; stall = 1'b1;
      set_in(1'b1, 16'hFFFF, 32'h400, 32'h77, 32'h55, 32'h66, 32'hCC, 32'hDD, 2'b01, 5'd9);
      set_exp(1'b0, 16'h0, 32'h0, 32'h77, 32'h55, 32'hDD, 5'd9);
      e.bc = 4'd1; e.sc = 4'd3;
      push("flush_and_stall");

      // 5. twenty flushes saturate the 4-bit bubble counter
      stall = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         e.bc = (e.bc == 4'd15) ? 4'd15 : e.bc + 4'd1;
         push($sformatf("flush_sat_%0d", i));
      end
      @(negedge clk);
      cnt_clr = 1'b1;
      e.bc = 4'd0; e.sc = 4'd0;
      push("clr_with_flush");
      @(negedge clk);
      flush = 1'b0; stall = 1'b1;
      push("clr_with_stall");
      @(negedge clk);
      cnt_clr = 1'b0;
      e.sc = 4'd1;
      push("stall_after_clr");

      // 6. async reset pulse in the middle of a stall
      @(negedge clk);
      set_in(1'b1, 16'h4321, 32'h500, 32'h88, 32'h12, 32'h34, 32'h56, 32'h78, 2'b10, 5'd11);
      e.sc = 4'd2;
      push("stall_before_rst");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      set_exp(1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
      e.bc = 4'd0; e.sc = 4'd0;
      push("async_rst_mid_stall");
      -> async_chk;
      @(negedge clk);
      rst_n = 1'b1; stall = 1'b0;
      set_exp(1'b1, 16'h4321, 32'h500, 32'h88, 32'h56, 32'h34, 5'd11);
      push("load_after_async_rst");

      @(negedge clk);
      @(negedge clk);
      stim_done = 1'b1;
   end

   initial begin : finisher
      int budget;
      budget = 0;
      while (!stim_done && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      n_cmp++;
      if (!stim_done) begin
         n_bad++;
         $display("FAIL timeout: got stimulus unfinished expected finished");
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
